// File: rtl/cpt_bin_down.sv
// ---------------------------------------------------------------------------
// cpt_bin_down -- loadable binary down-counter with one-shot / auto-reload
//
// Purpose:
//   Counts a loaded start value down to zero, one step per enabled clock
//   edge. When the count reaches its terminal step (out == 1 while enabled),
//   it either stops at 0 (one-shot) or reloads the start value (auto-reload).
//   In both cases a single-cycle terminal-count pulse is raised.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   asynchronous active-low reset
//   activate  in   count enable, one decrement per edge while high in RUN
//   load      in   synchronous load strobe, has priority over activate
//   load_val  in   [SIZE-1:0] start value captured on load
//   reload    in   1 = auto-reload, 0 = one-shot, sampled every edge
//   out       out  [SIZE-1:0] current count (registered)
//   busy      out  high while the state machine is in RUN (registered)
//   tc        out  terminal-count pulse, one cycle wide (registered)
// ---------------------------------------------------------------------------
module cpt_bin_down #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            activate,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            reload,
  output logic [SIZE-1:0] out,
  output logic            busy,
  output logic            tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q,   cnt_d;
  logic [SIZE-1:0] rld_q,   rld_d;
  logic            tc_q,    tc_d;

  // State register: every flop, including the count, is cleared by reset so
  // an in-flight count is aborted immediately without a terminal pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state logic. tc_d defaults low so the pulse lasts exactly one cycle
  // unless a new terminal event is produced on the following edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (load) begin
      // Load wins over activate and aborts any running count silently.
      cnt_d   = load_val;
      rld_d   = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && activate) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (cnt_q == ONE) begin
        tc_d = 1'b1;
        if (reload) begin
          cnt_d = rld_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        // RUN with a zero count is unreachable; fall back to IDLE rather
        // than wrapping below zero.
        state_d = IDLE;
      end
    end
  end

  // Output logic: all outputs come straight from flops.
  always_comb begin
    out  = cnt_q;
    busy = (state_q == RUN);
    tc   = tc_q;
  end

endmodule

// File: tb/tb_cpt_bin_down.sv
module tb_cpt_bin_down;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic       act8, ld8, rl8;
  logic [7:0] lv8;
  logic [7:0] out8;
  logic       busy8, tc8;

  logic       act1, ld1, rl1;
  logic [0:0] lv1;
  logic [0:0] out1;
  logic       busy1, tc1;

  cpt_bin_down #(.SIZE(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .activate (act8),
    .load     (ld8),
    .load_val (lv8),
    .reload   (rl8),
    .out      (out8),
    .busy     (busy8),
    .tc       (tc8)
  );

  cpt_bin_down #(.SIZE(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .activate (act1),
    .load     (ld1),
    .load_val (lv1),
    .reload   (rl1),
    .out      (out1),
    .busy     (busy1),
    .tc       (tc1)
  );

  typedef struct {
    int    o;
    int    b;
    int    t;
    string tag;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive one edge's worth of stimulus and queue the state expected after it.
  task automatic step8(input logic a, input logic l, input int v, input logic r,
                       input int eo, input int eb, input int et, input string tag);
    @(negedge clk);
    act8 = a; ld8 = l; lv8 = 8'(v); rl8 = r;
    q8.push_back('{o: eo, b: eb, t: et, tag: tag});
  endtask

  task automatic step1(input logic a, input logic l, input int v, input logic r,
                       input int eo, input int eb, input int et, input string tag);
    @(negedge clk);
    act1 = a; ld1 = l; lv1 = 1'(v); rl1 = r;
    q1.push_back('{o: eo, b: eb, t: et, tag: tag});
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    act8 = 1'b0; ld8 = 1'b0; lv8 = '0; rl8 = 1'b0;
    act1 = 1'b0; ld1 = 1'b0; lv1 = '0; rl1 = 1'b0;
  endtask

  // Monitor: after each rising edge, pop and compare whatever is pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        exp_t e;
        e = q8.pop_front();
        chk({e.tag, " out"},  int'(out8),  e.o);
        chk({e.tag, " busy"}, int'(busy8), e.b);
        chk({e.tag, " tc"},   int'(tc8),   e.t);
      end
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk({e.tag, " out"},  int'(out1),  e.o);
        chk({e.tag, " busy"}, int'(busy1), e.b);
        chk({e.tag, " tc"},   int'(tc1),   e.t);
      end
    end
  end

  initial begin
    reset = 1'b1;
    act8 = 1'b0; ld8 = 1'b0; lv8 = '0; rl8 = 1'b0;
    act1 = 1'b0; ld1 = 1'b0; lv1 = '0; rl1 = 1'b0;

    // Asynchronous reset with no clock edge involved.
    #2 reset = 1'b0;
    #1;
    chk("rst out8",  int'(out8),  0);
    chk("rst busy8", int'(busy8), 0);
    chk("rst tc8",   int'(tc8),   0);
    chk("rst out1",  int'(out1),  0);
    #19 reset = 1'b1;

    // One-shot: 3,2,1,0 with tc in the cycle out becomes 0.
    step8(0, 1, 3, 0, 3, 1, 0, "os_load");
    step8(1, 0, 0, 0, 2, 1, 0, "os_2");
    step8(1, 0, 0, 0, 1, 1, 0, "os_1");
    step8(1, 0, 0, 0, 0, 0, 1, "os_0");
    step8(1, 0, 0, 0, 0, 0, 0, "os_hold0");
    step8(1, 0, 0, 0, 0, 0, 0, "os_hold0b");

    // Auto-reload: 2,1,2,1,2,1,2 with tc on every return to 2.
    step8(0, 1, 2, 1, 2, 1, 0, "ar_load");
    step8(1, 0, 0, 1, 1, 1, 0, "ar_e1");
    step8(1, 0, 0, 1, 2, 1, 1, "ar_e2");
    step8(1, 0, 0, 1, 1, 1, 0, "ar_e3");
    step8(1, 0, 0, 1, 2, 1, 1, "ar_e4");
    step8(1, 0, 0, 1, 1, 1, 0, "ar_e5");
    step8(1, 0, 0, 1, 2, 1, 1, "ar_e6");

    // Gating: 4,3,3,2,2 with no tc.
    step8(0, 1, 4, 0, 4, 1, 0, "gt_load");
    step8(1, 0, 0, 0, 3, 1, 0, "gt_a1");
    step8(0, 0, 0, 0, 3, 1, 0, "gt_a0");
    step8(1, 0, 0, 0, 2, 1, 0, "gt_b1");
    step8(0, 0, 0, 0, 2, 1, 0, "gt_b0");

    // Priority / abort from RUN with out=2.
    step8(1, 1, 9, 0, 9, 1, 0, "pr_load9");
    step8(0, 1, 2, 0, 2, 1, 0, "pr_load2");
    step8(1, 1, 0, 0, 0, 0, 0, "pr_load0");
    step8(1, 0, 0, 0, 0, 0, 0, "pr_idle_ign");

    // Back-to-back reload of value 1: tc every cycle, then one-shot finish.
    step8(0, 1, 1, 1, 1, 1, 0, "r1_load");
    step8(1, 0, 0, 1, 1, 1, 1, "r1_e1");
    step8(1, 0, 0, 1, 1, 1, 1, "r1_e2");
    step8(1, 0, 0, 0, 0, 0, 1, "r1_end");
    step8(0, 0, 0, 0, 0, 0, 0, "r1_after");

    // Load from RUN at out=1 aborts without a tc pulse.
    step8(0, 1, 1, 0, 1, 1, 0, "ab_load1");
    step8(1, 1, 7, 0, 7, 1, 0, "ab_reload7");

    // Full width: 255 down to 0 in 255 enabled edges.
    step8(0, 1, 255, 0, 255, 1, 0, "w_load255");
    for (int i = 254; i >= 1; i--)
      step8(1, 0, 0, 0, i, 1, 0, $sformatf("w_%0d", i));
    step8(1, 0, 0, 0, 0, 0, 1, "w_0");
    step8(1, 0, 0, 0, 0, 0, 0, "w_hold");

    // Reset mid-count with out=5: cleared before the next edge.
    step8(0, 1, 5, 0, 5, 1, 0, "mr_load5");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mr out8",  int'(out8),  0);
    chk("mr busy8", int'(busy8), 0);
    chk("mr tc8",   int'(tc8),   0);
    #1 reset = 1'b1;
    step8(1, 0, 0, 0, 0, 0, 0, "mr_idle_ign");
    step8(1, 1, 3, 0, 3, 1, 0, "mr_reload3");
    idle_inputs();

    // SIZE=1 instance.
    step1(0, 1, 1, 0, 1, 1, 0, "s1_load");
    step1(1, 0, 0, 0, 0, 0, 1, "s1_0");
    step1(1, 0, 0, 0, 0, 0, 0, "s1_hold");
    step1(0, 1, 1, 1, 1, 1, 0, "s1_ar_load");
    step1(1, 0, 0, 1, 1, 1, 1, "s1_ar_e1");
    step1(1, 0, 0, 1, 1, 1, 1, "s1_ar_e2");
    idle_inputs();

    // Bounded drain of the scoreboard.
    repeat (5) @(posedge clk);
    #2;
    chk("drain pending", q8.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpt_bin_down.md
CPT_BIN_DOWN -- requirements
Module: cpt_bin_down

Interface
REQ-001 SHALL provide parameter: SIZE, default 8, counter width in bits (SIZE >= 1).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: activate  input  1  count enable; one decrement per clk edge while high.
REQ-005 SHALL provide port: load  input  1  synchronous load strobe.
REQ-006 SHALL provide port: load_val  input  SIZE  start value captured on load.
REQ-007 SHALL provide port: reload  input  1  mode select; 1 = auto-reload, 0 = one-shot; sampled every edge.
REQ-008 SHALL provide port: out  output  SIZE  current count, registered.
REQ-009 SHALL provide port: busy  output  1  high while the state machine is in RUN.
REQ-010 SHALL provide port: tc  output  1  terminal-count pulse, registered, one cycle wide.

Function
REQ-011 SHALL implement a two-state machine: IDLE, RUN.
REQ-012 SHALL hold an internal SIZE-bit reload register, written only on load.
REQ-013 On an edge with load=1, SHALL set out <= load_val and reload register <= load_val, in any state.
REQ-014 On load with load_val != 0, SHALL enter RUN; with load_val == 0, SHALL enter IDLE with tc=0.
REQ-015 load SHALL take priority over activate on the same edge; no decrement occurs that edge.
REQ-016 In RUN, on activate=1 and out > 1, SHALL set out <= out - 1 and stay in RUN.
REQ-017 In RUN, on activate=1, out == 1, reload=0, SHALL set out <= 0, enter IDLE, and assert tc for the next cycle.
REQ-018 In RUN, on activate=1, out == 1, reload=1, SHALL set out <= reload register, stay in RUN, and assert tc for the next cycle.
REQ-019 In RUN, on activate=0, SHALL hold out and state; tc=0.
REQ-020 In IDLE, SHALL ignore activate and hold out; out SHALL never wrap below 0.
REQ-021 tc SHALL be high for exactly one cycle per terminal event and low otherwise, including back-to-back reloads with SIZE'd value 1 (tc high every cycle is legal only then).
REQ-022 Load from RUN SHALL abort the current count without a tc pulse.
REQ-023 busy SHALL equal (state == RUN), registered; busy and tc high together only in auto-reload mode.
REQ-024 Arithmetic SHALL be modulo-free: decrement occurs only when out >= 1; no carry/borrow output.

Reset
REQ-025 While reset=0, SHALL force out=0, reload register=0, state=IDLE, busy=0, tc=0, independent of clk.
REQ-026 Reset assertion mid-count SHALL abort immediately with no tc pulse; after release, first edge behaves as in IDLE.
REQ-027 Reset release SHALL take effect on the first rising clk edge after reset goes high.

Verification
REQ-028 Reset: reset=0 during RUN with out=5 -> out=0, busy=0, tc=0 immediately, before next clk edge.
REQ-029 One-shot: SIZE=8, load_val=3, reload=0, activate held 1 -> out 3,2,1,0; tc high only in the cycle out=0; busy falls same cycle; out stays 0.
REQ-030 Auto-reload: load_val=2, reload=1, activate=1 for 6 edges -> out 2,1,2,1,2,1,2; tc high in each cycle out returns to 2.
REQ-031 Gating: load_val=4, activate toggles 1,0,1,0 -> out 4,3,3,2,2; no tc.
REQ-032 Priority/abort: in RUN with out=2, load=1 and activate=1 same edge, load_val=9 -> out=9, busy=1, no tc; load_val=0 -> out=0, IDLE, tc=0.
REQ-033 Width edge: SIZE=1, load_val=1, reload=0 -> out 1,0, one tc; SIZE=8, load_val=255 counts 255 down to 0 in 255 enabled edges.
